key_expansion_controller: RTL
=============================

Name: key_expansion_controller

Overview:
- Sequences the AES-128 key schedule by driving one G_Function instance iteratively, one round per clock, for rounds 1..10.
- Stores all 11 round keys (round 0 = cipher key) in an internal register file.
- Exposes a random-access read port so the encryption/decryption round controller can fetch any round key after expansion completes.

Parameters:
- NUM_ROUNDS, 10, number of expanded round keys; only 10 (AES-128) is supported.
- ROUND_W, 4, width of round index; must hold 0..NUM_ROUNDS.

Ports:
- i_clk  input  1  clock, rising-edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle request to expand i_key.
- i_key  input  128  cipher key; [127:120] = byte 0 of word w0, [31:0] = w3.
- o_busy  output  1  high while expansion is in progress.
- o_done  output  1  one-cycle pulse when round key 10 has been written.
- i_rdRound  input  4  round-key index to read (0..10).
- o_rdKey  output  128  round key at i_rdRound; combinational read of the register file.
- o_rdValid  output  1  high when i_rdRound <= highest round written since the last accepted start.

Behaviour:
- Reset (i_rst=1 at a clock edge): state=IDLE; o_busy=0; o_done=0; round counter=0; all 11 key registers=0; written-round marker=invalid, so o_rdValid=0. Reset wins over every other input, including mid-expansion.
- States:
  - IDLE
    - i_start=1: write i_key to key[0]; set marker=0; round counter=1; go to EXPAND.
  - EXPAND
    - Each cycle: compute the key for round r from key[r-1] = {w0,w1,w2,w3}.
    - g = G_Function(r, w3 bytes [31:24],[23:16],[15:8],[7:0]).
    - n0=w0^g; n1=n0^w1; n2=n1^w2; n3=n2^w3; write {n0,n1,n2,n3} to key[r]; marker=r.
    - If r==10: go to DONE; else r=r+1.
  - DONE
    - o_done=1 for exactly this cycle; next state IDLE.
    - i_start=1 in DONE is accepted exactly as in IDLE; o_done still pulses this cycle.
- o_busy=1 in EXPAND only.
- Latency: start accepted at edge 0 → key[r] written at edge r → o_done high during the cycle after edge 10. Total 11 cycles from start to o_done.
- i_start while in EXPAND: ignored; the current expansion continues unchanged.
- i_key is sampled only at the accepting edge; later changes have no effect.
- Read port:
  - o_rdKey = key[i_rdRound] with no registering.
  - i_rdRound > 10: o_rdKey=0, o_rdValid=0.
  - A round being written this cycle reads its old value until the edge (no bypass).
- A new accepted start resets the marker to 0. Previously stored keys 1..10 remain readable but are flagged invalid until rewritten.
- Round counter never exceeds 10 and never wraps.
- The G_Function round input carries values 1..10 only.

Decomposition:
- Shared package aes_pkg:
  - AES_NUM_ROUNDS=10.
  - round_key_t (128-bit) and word_t (32-bit) typedefs.
  - State encoding enum {IDLE, EXPAND, DONE}.
- Sub-module: key_round_step (combinational). Wraps G_Function plus the four-word XOR chain: previous key + round number → next key. The controller holds only the FSM, counter, marker and register file.

Test Plan:
- FIPS-197 vector: i_key=2b7e151628aed2a6abf7158809cf4f3c, pulse i_start → o_busy high for 10 cycles; o_done pulses 11 cycles after start.
  - Round 1 reads a0fafe1788542cb123a339392a6c7605.
  - Round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 0 reads the key.
  - o_rdValid=1 for rounds 0..10.
- Progressive valid: during expansion, poll i_rdRound=5 → o_rdValid=0 until the edge writing key[5], then 1 with value d4d1c6f87c839d87caf2b8bc11f915bc.
- Start while busy: second i_start with a different key at cycle 4 → ignored; final keys match the first key; exactly one o_done.
- Reset mid-operation: assert i_rst at cycle 6 → next cycle o_busy=0, o_rdValid=0 for all rounds, o_rdKey=0; a fresh start then completes correctly.
- Back-to-back: i_start asserted in the DONE cycle with key 000102030405060708090a0b0c0d0e0f → accepted; o_done pulses again 11 cycles later; round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Out-of-range read: i_rdRound=11..15 → o_rdKey=0, o_rdValid=0 in every state.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, state encoding and byte-level helpers.
// S-box and round constants are pure lookups used by the combinational round step.
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;

    typedef logic [127:0] round_key_t;
    typedef logic [31:0]  word_t;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // G_Function: RotWord, SubWord, then XOR the round constant into the top byte.
    function automatic word_t g_function(input logic [3:0] r, input word_t w);
        return {sub_byte(w[23:16]) ^ rcon(r), sub_byte(w[15:8]),
                sub_byte(w[7:0]), sub_byte(w[31:24])};
    endfunction

endpackage

// File: rtl/key_expansion_controller_step.sv
// One AES-128 key-schedule round: previous round key + round number -> next round key.
// Purely combinational; no handshake.
module key_round_step
    import aes_pkg::*;
(
    input  round_key_t  i_prevKey,
    input  logic [3:0]  i_round,
    output round_key_t  o_nextKey
);

    word_t w_w0, w_w1, w_w2, w_w3;
    word_t w_g, w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = i_prevKey;
    assign w_g       = g_function(i_round, w_w3);
    assign w_n0      = w_w0 ^ w_g;
    assign w_n1      = w_n0 ^ w_w1;
    assign w_n2      = w_n1 ^ w_w2;
    assign w_n3      = w_n2 ^ w_w3;
    assign o_nextKey = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/key_expansion_controller.sv
// AES-128 key-schedule sequencer: one round per clock, 11 cycles from accepted start to o_done.
// Starts during expansion are dropped; the read port is a combinational view of the key file.
module key_expansion_controller
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int ROUND_W    = 4
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [127:0]        i_key,
    output logic                o_busy,
    output logic                o_done,
    input  logic [ROUND_W-1:0]  i_rdRound,
    output logic [127:0]        o_rdKey,
    output logic                o_rdValid
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    state_t             r_state, w_nextState;
    logic [ROUND_W-1:0] r_round;
    logic [ROUND_W-1:0] r_marker;
    logic               r_markerVld;
    round_key_t         r_keys [0:NUM_ROUNDS];

    logic               w_accept, w_step, w_rdInRange;
    logic [ROUND_W-1:0] w_prevIdx;
    logic [3:0]         w_stepRound;
    round_key_t         w_prevKey, w_nextKey;

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_nextState = EXPAND;
                end else begin
                    w_nextState = IDLE;
                end
            end
            EXPAND: begin
                w_step = 1'b1;
                if (r_round == LAST_ROUND) begin
                    w_nextState = DONE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Counter sits at 0 only after reset; clamp so the step never sees round 0.
    assign w_prevIdx   = (r_round == '0) ? '0 : r_round - 1'b1;
    assign w_stepRound = (r_round == '0) ? 4'd1 : 4'(r_round);
    assign w_prevKey   = r_keys[w_prevIdx];

    key_round_step u_step (
        .i_prevKey (w_prevKey),
        .i_round   (w_stepRound),
        .o_nextKey (w_nextKey)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_round     <= '0;
            r_marker    <= '0;
            r_markerVld <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_keys[i] <= '0;
            end
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_keys[0]   <= i_key;
                r_marker    <= '0;
                r_markerVld <= 1'b1;
                r_round     <= ROUND_W'(1);
            end else if (w_step) begin
                r_keys[r_round] <= w_nextKey;
                r_marker        <= r_round;
                if (r_round != LAST_ROUND) begin
                    r_round <= r_round + 1'b1;
                end
            end
        end
    end

    assign o_busy      = (r_state == EXPAND);
    assign o_done      = (r_state == DONE);
    assign w_rdInRange = (i_rdRound <= LAST_ROUND);
    assign o_rdKey     = w_rdInRange ? r_keys[i_rdRound] : '0;
    assign o_rdValid   = w_rdInRange && r_markerVld && (i_rdRound <= r_marker);

endmodule
